// File: rtl/fft_fp_pkg.sv
// Shared single-precision constants and helpers for the FFT constant-multiplier datapath.
package fft_fp_pkg;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;
  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam logic [31:0] FP_ZERO = 32'h0;

  // Number of operands present at level k of a pairwise reduction of n inputs.
  function automatic int unsigned lvl_cnt(input int unsigned n, input int unsigned k);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Index of the first node of level k in a flat array holding every tree level.
  function automatic int unsigned lvl_off(input int unsigned n, input int unsigned k);
    int unsigned o;
    o = 0;
    for (int unsigned i = 0; i < k; i++) o = o + lvl_cnt(n, i);
    return o;
  endfunction

  // IEEE-754 single add, round-to-nearest-even. Denormal operands count as zero
  // and results below the normal range flush to signed zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, r;
    logic [7:0]  ex, ey, dexp;
    logic [26:0] xa, yb, ysh, nm;
    logic [27:0] sum;
    logic [24:0] rm;
    logic [9:0]  e;
    logic        sticky, rnd;
    int unsigned lz;
    ex = a[EXP_MSB:EXP_LSB];
    ey = b[EXP_MSB:EXP_LSB];
    r  = FP_ZERO;
    if (ex == EXP_INF || ey == EXP_INF) begin
      if (ex == EXP_INF && a[22:0] != '0)      r = a | 32'h0040_0000;
      else if (ey == EXP_INF && b[22:0] != '0) r = b | 32'h0040_0000;
      else if (ex == EXP_INF && ey == EXP_INF && a[31] != b[31]) r = 32'h7FC0_0000;
      else if (ex == EXP_INF)                  r = a;
      else                                     r = b;
    end else if (ex == '0 && ey == '0) begin
      r = {a[31] & b[31], 31'b0};
    end else if (ex == '0) begin
      r = b;
    end else if (ey == '0) begin
      r = a;
    end else begin
      if (a[30:0] >= b[30:0]) begin
        x = a; y = b;
      end else begin
        x = b; y = a;
      end
      dexp = x[EXP_MSB:EXP_LSB] - y[EXP_MSB:EXP_LSB];
      xa   = {1'b1, x[22:0], 3'b000};
      yb   = {1'b1, y[22:0], 3'b000};
      if (dexp >= 8'd27) begin
        ysh = 27'd1;
      end else begin
        ysh    = yb >> dexp;
        sticky = |(yb & ~({27{1'b1}} << dexp));
        ysh[0] = ysh[0] | sticky;
      end
      if (x[31] == y[31]) sum = {1'b0, xa} + {1'b0, ysh};
      else                sum = {1'b0, xa} - {1'b0, ysh};
      if (sum == '0) begin
        r = FP_ZERO;
      end else begin
        e = {2'b00, x[EXP_MSB:EXP_LSB]};
        if (sum[27]) begin
          nm = {sum[27:2], sum[1] | sum[0]};
          e  = e + 10'd1;
        end else begin
          lz = 0;
          for (int unsigned i = 0; i < 27; i++) if (sum[i]) lz = 26 - i;
          nm = sum[26:0] << lz;
          e  = e - lz[9:0];
        end
        rnd = nm[2] & (nm[1] | nm[0] | nm[3]);
        rm  = {1'b0, nm[26:3]} + {24'b0, rnd};
        if (rm[24]) begin
          rm = rm >> 1;
          e  = e + 10'd1;
        end
        if ($signed(e) <= 0)        r = {x[31], 31'b0};
        else if ($signed(e) >= 255) r = {x[31], EXP_INF, 23'b0};
        else                        r = {x[31], e[7:0], rm[22:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/Complex_adder.sv
// Complex single-precision adder with LAT pipeline stages on the result.
module Complex_adder
  import fft_fp_pkg::*;
#(
  parameter int unsigned LAT = 1
)(
  input  logic            clk,
  input  logic [FP_W-1:0] a_re_i,
  input  logic [FP_W-1:0] a_im_i,
  input  logic [FP_W-1:0] b_re_i,
  input  logic [FP_W-1:0] b_im_i,
  output logic [FP_W-1:0] s_re_o,
  output logic [FP_W-1:0] s_im_o
);

  logic [FP_W-1:0] sum_re_d, sum_im_d;

  // Component-wise IEEE addition.
  always_comb begin
    sum_re_d = fp_add(a_re_i, b_re_i);
    sum_im_d = fp_add(a_im_i, b_im_i);
  end

  if (LAT == 0) begin : g_comb
    assign s_re_o = sum_re_d;
    assign s_im_o = sum_im_d;
  end else begin : g_pipe
    logic [FP_W-1:0] re_q [LAT];
    logic [FP_W-1:0] im_q [LAT];

    // Result delay line; data needs no reset, validity is tracked by the caller.
    always_ff @(posedge clk) begin
      re_q[0] <= sum_re_d;
      im_q[0] <= sum_im_d;
      for (int unsigned i = 1; i < LAT; i++) begin
        re_q[i] <= re_q[i-1];
        im_q[i] <= im_q[i-1];
      end
    end

    assign s_re_o = re_q[LAT-1];
    assign s_im_o = im_q[LAT-1];
  end

endmodule

// File: rtl/pow2_scale.sv
// Multiplies one single-precision component by +/-2^-shift via exponent subtraction.
module pow2_scale
  import fft_fp_pkg::*;
(
  input  logic [FP_W-1:0] x,
  input  logic [7:0]      shift,
  input  logic            neg,
  output logic [FP_W-1:0] y
);

  logic [7:0] e;
  assign e = x[EXP_MSB:EXP_LSB];

  // Inf/NaN pass, zero/denormal/underflow flush to signed zero, then optional sign flip.
  always_comb begin
    y = x;
    if (e == EXP_INF) begin
      y = x;
    end else if (e <= shift) begin
      y = {x[FP_W-1], {(FP_W-1){1'b0}}};
    end else begin
      y[EXP_MSB:EXP_LSB] = e - shift;
    end
    y[FP_W-1] = y[FP_W-1] ^ neg;
  end

endmodule

// File: rtl/csd_const_mult.sv
// Pipelined complex multiply by a CSD constant: sum of +/-2^-s terms, optional conjugate.
module csd_const_mult
  import fft_fp_pkg::*;
#(
  parameter int unsigned NUM_TERMS   = 5,
  parameter logic [63:0] TERM_SHIFTS = 64'h0000_0008_0605_0402,
  parameter logic [7:0]  TERM_SIGNS  = 8'h00,
  parameter bit          NEG_OUT     = 1'b1,
  parameter int unsigned ADD_LAT     = 1
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [FP_W-1:0] a_re,
  input  logic [FP_W-1:0] a_img,
  input  logic            conj_sel,
  output logic            out_valid,
  output logic [FP_W-1:0] a1_re,
  output logic [FP_W-1:0] a1_img
);

  localparam int unsigned D     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 0;
  localparam int unsigned NODES = lvl_off(NUM_TERMS, D + 1);
  localparam int unsigned PIPE  = 2 + D * ADD_LAT;

  logic [FP_W-1:0] a_re_q, a_img_q;
  logic [PIPE-1:0] vld_q, conj_q;
  logic [FP_W-1:0] sc_re   [NUM_TERMS];
  logic [FP_W-1:0] sc_im   [NUM_TERMS];
  logic [FP_W-1:0] t_re_q  [NUM_TERMS];
  logic [FP_W-1:0] t_im_q  [NUM_TERMS];
  logic [FP_W-1:0] node_re [NODES];
  logic [FP_W-1:0] node_im [NODES];
  logic [FP_W-1:0] re_d, img_d;
  logic [FP_W-1:0] a1_re_q, a1_img_q;
  logic            out_valid_q;

  // Input capture; data is only meaningful alongside a set valid bit.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      a_re_q  <= a_re;
      a_img_q <= a_img;
    end
  end

  // Valid and conjugate flags travel beside the data through every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      conj_q <= '0;
    end else begin
      vld_q  <= {vld_q[PIPE-2:0], in_valid};
      conj_q <= {conj_q[PIPE-2:0], conj_sel};
    end
  end

  for (genvar i = 0; i < NUM_TERMS; i++) begin : g_term
    pow2_scale u_sc_re (
      .x     (a_re_q),
      .shift (TERM_SHIFTS[8*i +: 8]),
      .neg   (TERM_SIGNS[i]),
      .y     (sc_re[i])
    );
    pow2_scale u_sc_im (
      .x     (a_img_q),
      .shift (TERM_SHIFTS[8*i +: 8]),
      .neg   (TERM_SIGNS[i]),
      .y     (sc_im[i])
    );
    assign node_re[i] = t_re_q[i];
    assign node_im[i] = t_im_q[i];
  end

  // Scale stage register: one complex term per CSD digit.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_TERMS; i++) begin
      t_re_q[i] <= sc_re[i];
      t_im_q[i] <= sc_im[i];
    end
  end

  // Tree levels live back to back in node_*; an unpaired operand rides a delay
  // line of adder length so each level stays cycle-aligned.
  for (genvar k = 1; k <= D; k++) begin : g_lvl
    localparam int unsigned NP = lvl_cnt(NUM_TERMS, k - 1);
    localparam int unsigned NC = lvl_cnt(NUM_TERMS, k);
    localparam int unsigned OP = lvl_off(NUM_TERMS, k - 1);
    localparam int unsigned OC = lvl_off(NUM_TERMS, k);
    for (genvar j = 0; j < NC; j++) begin : g_node
      if (2 * j + 1 < NP) begin : g_add
        Complex_adder #(.LAT(ADD_LAT)) u_add (
          .clk    (clk),
          .a_re_i (node_re[OP + 2*j]),
          .a_im_i (node_im[OP + 2*j]),
          .b_re_i (node_re[OP + 2*j + 1]),
          .b_im_i (node_im[OP + 2*j + 1]),
          .s_re_o (node_re[OC + j]),
          .s_im_o (node_im[OC + j])
        );
      end else if (ADD_LAT == 0) begin : g_wire
        assign node_re[OC + j] = node_re[OP + 2*j];
        assign node_im[OC + j] = node_im[OP + 2*j];
      end else begin : g_dly
        logic [FP_W-1:0] dre_q [ADD_LAT];
        logic [FP_W-1:0] dim_q [ADD_LAT];
        // Leftover operand delay matching one adder.
        always_ff @(posedge clk) begin
          dre_q[0] <= node_re[OP + 2*j];
          dim_q[0] <= node_im[OP + 2*j];
          for (int unsigned s = 1; s < ADD_LAT; s++) begin
            dre_q[s] <= dre_q[s-1];
            dim_q[s] <= dim_q[s-1];
          end
        end
        assign node_re[OC + j] = dre_q[ADD_LAT-1];
        assign node_im[OC + j] = dim_q[ADD_LAT-1];
      end
    end
  end

  // Final sign handling: global negation plus per-sample conjugate on imag.
  always_comb begin
    re_d      = node_re[NODES-1];
    img_d     = node_im[NODES-1];
    re_d[31]  = re_d[31] ^ NEG_OUT;
    img_d[31] = img_d[31] ^ NEG_OUT ^ conj_q[PIPE-1];
  end

  // Output register holds its last value across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a1_re_q     <= '0;
      a1_img_q    <= '0;
    end else begin
      out_valid_q <= vld_q[PIPE-1];
      if (vld_q[PIPE-1]) begin
        a1_re_q  <= re_d;
        a1_img_q <= img_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign a1_re     = a1_re_q;
  assign a1_img    = a1_img_q;

endmodule

// File: tb/tb_csd_const_mult.sv
// Self-checking bench: default -93/256 multiplier plus a single-term (x/2) variant.
module tb_csd_const_mult;

  localparam int          LAT0   = 6;
  localparam int          LAT1   = 3;
  localparam logic [63:0] DEF_SH = 64'h0000_0008_0605_0402;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        conj_sel = 1'b0;
  logic [31:0] a_re = '0, a_img = '0;
  logic        out_valid, out_valid1;
  logic [31:0] a1_re, a1_img, b1_re, b1_img;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  csd_const_mult u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_re(a_re), .a_img(a_img),
    .conj_sel(conj_sel), .out_valid(out_valid), .a1_re(a1_re), .a1_img(a1_img)
  );

  csd_const_mult #(
    .NUM_TERMS(1), .TERM_SHIFTS(64'h1), .TERM_SIGNS(8'h00), .NEG_OUT(1'b0), .ADD_LAT(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_re(a_re), .a_img(a_img),
    .conj_sel(conj_sel), .out_valid(out_valid1), .a1_re(b1_re), .a1_img(b1_img)
  );

  function automatic real sf2real(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e11;
    if (x[30:23] == 8'd0) d = {x[31], 63'b0};
    else begin
      e11 = {3'b0, x[30:23]} + 11'd896;
      d   = {x[31], e11, x[22:0], 29'b0};
    end
    return $bitstoreal(d);
  endfunction

  // Values reaching here are exact singles in normal range (or signed zero).
  function automatic logic [31:0] real2sf(input real r);
    logic [63:0] d;
    logic [10:0] e11;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'b0};
    e11 = d[62:52] - 11'd896;
    return {d[63], e11[7:0], d[51:29]};
  endfunction

  // Reference: scaled terms summed pairwise level by level, leftover carried up.
  function automatic logic [31:0] model(input logic [31:0] x, input int unsigned nt,
                                        input logic [63:0] sh, input logic [7:0] sg,
                                        input logic ng);
    real         t[8];
    int unsigned n;
    logic [7:0]  e, s;
    e = x[30:23];
    for (int unsigned i = 0; i < nt; i++) begin
      s = sh[8*i +: 8];
      if (e <= s) t[i] = sf2real({x[31], 31'b0});
      else begin
        t[i] = sf2real(x);
        for (int unsigned k = 0; k < s; k++) t[i] = t[i] / 2.0;
      end
      if (sg[i]) t[i] = -t[i];
    end
    n = nt;
    while (n > 1) begin
      for (int unsigned j = 0; j < (n + 1) / 2; j++)
        t[j] = (2*j + 1 < n) ? t[2*j] + t[2*j+1] : t[2*j];
      n = (n + 1) / 2;
    end
    return real2sf(ng ? -t[0] : t[0]);
  endfunction

  // Random normal single with a short mantissa so every partial sum is exact.
  function automatic logic [31:0] rnd_fp();
    logic [11:0] m;
    logic [7:0]  e;
    logic        s;
    m = 12'($urandom);
    e = 8'($urandom_range(150, 100));
    s = 1'($urandom);
    return {s, e, m, 11'b0};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if (a1_re !== 32'h0) begin n_err++; $display("FAIL reset_re got %h want 00000000", a1_re); end
    n_vec++; if (a1_img !== 32'h0) begin n_err++; $display("FAIL reset_img got %h want 00000000", a1_img); end
    n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_valid1 got %b want 0", out_valid1); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] vr[4] = '{32'h3F800000, 32'h43800000, 32'h01800000, 32'h7F800000};
    logic [31:0] vi[4] = '{32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000};
    logic        vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] er[4] = '{32'hBEBA0000, 32'hC2BA0000, 32'h80800000, 32'hFF800000};
    logic [31:0] ei[4] = '{32'h80000000, 32'h3EBA0000, 32'h80000000, 32'h80000000};
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      in_valid = 1'b1; a_re = vr[v]; a_img = vi[v]; conj_sel = vc[v];
      for (int c = 1; c <= LAT0; c++) begin
        @(negedge clk);
        in_valid = 1'b0; a_re = '0; a_img = '0; conj_sel = 1'b0;
        if (c == LAT0 - 1) begin
          n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_early got %b want 0", v, out_valid); end
        end
      end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_valid got %b want 1", v, out_valid); end
      n_vec++; if (a1_re !== er[v]) begin n_err++; $display("FAIL dir%0d_re got %h want %h", v, a1_re, er[v]); end
      n_vec++; if (a1_img !== ei[v]) begin n_err++; $display("FAIL dir%0d_img got %h want %h", v, a1_img, ei[v]); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_drop got %b want 0", v, out_valid); end
      n_vec++; if (a1_re !== er[v]) begin n_err++; $display("FAIL dir%0d_hold got %h want %h", v, a1_re, er[v]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_term();
    @(negedge clk);
    in_valid = 1'b1; a_re = 32'h40400000; a_img = 32'hC0400000; conj_sel = 1'b0;
    for (int c = 1; c <= LAT1; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c == LAT1 - 1) begin
        n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL one_early got %b want 0", out_valid1); end
      end
    end
    n_vec++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL one_valid got %b want 1", out_valid1); end
    n_vec++; if (b1_re !== 32'h3FC00000) begin n_err++; $display("FAIL one_re got %h want 3fc00000", b1_re); end
    n_vec++; if (b1_img !== 32'hBFC00000) begin n_err++; $display("FAIL one_img got %h want bfc00000", b1_img); end
    repeat (LAT0 + 2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    localparam int NS = 24;
    logic        vin[NS];
    logic        cj[NS];
    logic [31:0] xr[NS], xi[NS];
    logic        ev;
    logic [31:0] er, ei;
    int          k;
    for (int i = 0; i < NS; i++) begin
      vin[i] = (i < 20) ? 1'b1 : ((i % 2) == 0);
      xr[i]  = rnd_fp();
      xi[i]  = rnd_fp();
      cj[i]  = 1'($urandom);
    end
    for (int n = 0; n < NS + LAT0 + 2; n++) begin
      @(negedge clk);
      k  = n - LAT0;
      ev = (k >= 0 && k < NS) ? vin[k] : 1'b0;
      n_vec++; if (out_valid !== ev) begin n_err++; $display("FAIL b2b_valid n=%0d got %b want %b", n, out_valid, ev); end
      if (ev) begin
        er = model(xr[k], 5, DEF_SH, 8'h00, 1'b1);
        ei = model(xi[k], 5, DEF_SH, 8'h00, 1'b1 ^ cj[k]);
        n_vec++; if (a1_re !== er) begin n_err++; $display("FAIL b2b_re n=%0d got %h want %h", n, a1_re, er); end
        n_vec++; if (a1_img !== ei) begin n_err++; $display("FAIL b2b_img n=%0d got %h want %h", n, a1_img, ei); end
      end
      k  = n - LAT1;
      ev = (k >= 0 && k < NS) ? vin[k] : 1'b0;
      n_vec++; if (out_valid1 !== ev) begin n_err++; $display("FAIL b2b1_valid n=%0d got %b want %b", n, out_valid1, ev); end
      if (ev) begin
        er = model(xr[k], 1, 64'h1, 8'h00, 1'b0);
        ei = model(xi[k], 1, 64'h1, 8'h00, cj[k]);
        n_vec++; if (b1_re !== er) begin n_err++; $display("FAIL b2b1_re n=%0d got %h want %h", n, b1_re, er); end
        n_vec++; if (b1_img !== ei) begin n_err++; $display("FAIL b2b1_img n=%0d got %h want %h", n, b1_img, ei); end
      end
      if (n < NS) begin
        in_valid = vin[n]; a_re = xr[n]; a_img = xi[n]; conj_sel = cj[n];
      end else begin
        in_valid = 1'b0; a_re = '0; a_img = '0; conj_sel = 1'b0;
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a_re = rnd_fp(); a_img = rnd_fp(); conj_sel = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
    n_vec++; if (a1_re !== 32'h0) begin n_err++; $display("FAIL rst_async_re got %h want 00000000", a1_re); end
    n_vec++; if (a1_img !== 32'h0) begin n_err++; $display("FAIL rst_async_img got %h want 00000000", a1_img); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0 || a1_re !== 32'h0) begin
        n_err++; $display("FAIL rst_stale c=%0d got v=%b re=%h want v=0 re=00000000", c, out_valid, a1_re);
      end
    end
    in_valid = 1'b1; a_re = 32'h3F800000; a_img = 32'h3F800000; conj_sel = 1'b1;
    for (int c = 1; c <= LAT0; c++) begin
      @(negedge clk);
      in_valid = 1'b0; conj_sel = 1'b0;
      if (c == LAT0 - 1) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_next_early got %b want 0", out_valid); end
      end
    end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_next_valid got %b want 1", out_valid); end
    n_vec++; if (a1_re !== 32'hBEBA0000) begin n_err++; $display("FAIL rst_next_re got %h want beba0000", a1_re); end
    n_vec++; if (a1_img !== 32'h3EBA0000) begin n_err++; $display("FAIL rst_next_img got %h want 3eba0000", a1_img); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_single_term();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
